// File: rtl/score_display_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : score_display_pkg
//  Description : Shared types and segment/anode constants for the score
//                display scanner.
//  Revision    : 1.0 - initial release
// ============================================================================
package score_display_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LATCH = 3'd1,
        ST_DIG0  = 3'd2,
        ST_DIG1  = 3'd3,
        ST_DIG2  = 3'd4
    } scan_state_t;

    // Active-low segment patterns, bit order {g,f,e,d,c,b,a}
    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_E     = 7'b0000110;
    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;

    localparam logic [2:0] ANODE_OFF = 3'b111;

endpackage : score_display_pkg
`default_nettype wire

// File: rtl/bcd_to_seg7.sv
`default_nettype none
// ============================================================================
//  Module      : bcd_to_seg7
//  Description : Combinational BCD to active-low 7-segment decoder; codes
//                10..15 show "E".
//  Revision    : 1.0 - initial release
// ============================================================================
module bcd_to_seg7
    import score_display_pkg::*;
(
    input  logic [3:0] i_digit,
    output logic [6:0] o_seg
);

    always_comb begin
        o_seg = SEG_E;
        case (i_digit)
            4'd0:    o_seg = SEG_0;
            4'd1:    o_seg = SEG_1;
            4'd2:    o_seg = SEG_2;
            4'd3:    o_seg = SEG_3;
            4'd4:    o_seg = SEG_4;
            4'd5:    o_seg = SEG_5;
            4'd6:    o_seg = SEG_6;
            4'd7:    o_seg = SEG_7;
            4'd8:    o_seg = SEG_8;
            4'd9:    o_seg = SEG_9;
            default: o_seg = SEG_E;
        endcase
    end

endmodule : bcd_to_seg7
`default_nettype wire

// File: rtl/score_display_scanner.sv
`default_nettype none
// ============================================================================
//  Module      : score_display_scanner
//  Description : Frame-snapshotting 3-digit multiplexed 7-segment driver with
//                leading-zero blanking. Optional score-change blink is
//                enabled with the SCORE_BLINK_EN macro.
//  Revision    : 1.0 - initial release
// ============================================================================
module score_display_scanner
    import score_display_pkg::*;
#(
    parameter int SCAN_DIV = 50000
`ifdef SCORE_BLINK_EN
    ,
    parameter int BLINK_FRAMES = 8
`endif
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic [3:0] scoreOne,
    input  logic [3:0] scoreTen,
    input  logic [3:0] scoreHundred,
    output logic [2:0] anodeN,
    output logic [6:0] segN,
    output logic       frameDone
);

    localparam int c_presc_w = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [c_presc_w-1:0] c_presc_tc = c_presc_w'(SCAN_DIV - 1);

    scan_state_t          r_state;
    scan_state_t          w_state_next;
    logic [c_presc_w-1:0] r_presc;
    logic [c_presc_w-1:0] w_presc_next;
    logic                 w_presc_tc;
    logic                 w_fd_next;

    logic [3:0] r_snap_one, r_snap_ten, r_snap_hun;
    logic [3:0] w_snap_one, w_snap_ten, w_snap_hun;
    logic       w_capture;

    logic [3:0] w_dec_in;
    logic [6:0] w_dec_seg;
    logic       w_digit_on;
    logic       w_digit_blank;
    logic       w_blink_off;
    logic [2:0] w_anode_next;
    logic [6:0] w_seg_next;

    assign w_presc_tc = (r_presc == c_presc_tc);

    // ------------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_presc <= '0;
        end else begin
            r_state <= w_state_next;
            r_presc <= w_presc_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_presc_next = '0;
        w_fd_next    = 1'b0;
        if ((r_state != ST_IDLE) && !enable) begin
            w_state_next = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE:  if (enable) w_state_next = ST_LATCH;
                ST_LATCH: w_state_next = ST_DIG0;
                ST_DIG0: begin
                    if (w_presc_tc) w_state_next = ST_DIG1;
                    else            w_presc_next = r_presc + 1'b1;
                end
                ST_DIG1: begin
                    if (w_presc_tc) w_state_next = ST_DIG2;
                    else            w_presc_next = r_presc + 1'b1;
                end
                ST_DIG2: begin
                    if (w_presc_tc) begin
                        w_state_next = ST_LATCH;
                        w_fd_next    = 1'b1;
                    end else begin
                        w_presc_next = r_presc + 1'b1;
                    end
                end
                default: w_state_next = ST_IDLE;
            endcase
        end
    end

    // The snapshot takes the inputs seen during LATCH; DIG0 decodes the
    // freshly captured value on the same edge it is stored.
    assign w_capture  = (r_state == ST_LATCH) && enable;
    assign w_snap_one = w_capture ? scoreOne     : r_snap_one;
    assign w_snap_ten = w_capture ? scoreTen     : r_snap_ten;
    assign w_snap_hun = w_capture ? scoreHundred : r_snap_hun;

    always_comb begin
        w_dec_in      = w_snap_one;
        w_digit_on    = 1'b0;
        w_digit_blank = 1'b0;
        w_anode_next  = ANODE_OFF;
        case (w_state_next)
            ST_DIG0: begin
                w_dec_in     = w_snap_one;
                w_digit_on   = 1'b1;
                w_anode_next = 3'b110;
            end
            ST_DIG1: begin
                w_dec_in      = w_snap_ten;
                w_digit_on    = 1'b1;
                w_digit_blank = (w_snap_hun == 4'd0) && (w_snap_ten == 4'd0);
                w_anode_next  = 3'b101;
            end
            ST_DIG2: begin
                w_dec_in      = w_snap_hun;
                w_digit_on    = 1'b1;
                w_digit_blank = (w_snap_hun == 4'd0);
                w_anode_next  = 3'b011;
            end
            default: ;
        endcase
    end

    bcd_to_seg7 u_dec (
        .i_digit (w_dec_in),
        .o_seg   (w_dec_seg)
    );

    assign w_seg_next = (w_digit_on && !w_digit_blank && !w_blink_off) ? w_dec_seg : SEG_BLANK;

`ifdef SCORE_BLINK_EN
    localparam int c_blink_w = $clog2(BLINK_FRAMES + 1);

    logic [c_blink_w-1:0] r_blink_cnt;
    logic [c_blink_w-1:0] w_blink_next;
    logic                 w_changed;

    // r_snap_* still holds the previous frame's value while LATCH captures
    assign w_changed = w_capture &&
                       ({scoreHundred, scoreTen, scoreOne} != {r_snap_hun, r_snap_ten, r_snap_one});

    always_comb begin
        w_blink_next = r_blink_cnt;
        if (w_changed)
            w_blink_next = c_blink_w'(BLINK_FRAMES);
        else if (w_fd_next && (r_blink_cnt != '0))
            w_blink_next = r_blink_cnt - 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) r_blink_cnt <= '0;
        else       r_blink_cnt <= w_blink_next;
    end

    assign w_blink_off = w_blink_next[0];
`else
    assign w_blink_off = 1'b0;
`endif

    // ------------------------------------------------------------------------
    // Snapshot and registered outputs
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_snap_one <= 4'd0;
            r_snap_ten <= 4'd0;
            r_snap_hun <= 4'd0;
            anodeN     <= ANODE_OFF;
            segN       <= SEG_BLANK;
            frameDone  <= 1'b0;
        end else begin
            r_snap_one <= w_snap_one;
            r_snap_ten <= w_snap_ten;
            r_snap_hun <= w_snap_hun;
            anodeN     <= w_anode_next;
            segN       <= w_seg_next;
            frameDone  <= w_fd_next;
        end
    end

endmodule : score_display_scanner
`default_nettype wire

// File: tb/tb_score_display_scanner.sv
`default_nettype none
// ============================================================================
//  Module      : tb_score_display_scanner
//  Description : Randomized self-checking bench comparing the scanner against
//                a frame-position reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_score_display_scanner;

    localparam int SCAN_DIV     = 4;
    localparam int BLINK_FRAMES = 4;
    localparam int FRAME        = 1 + 3 * SCAN_DIV;

    logic       clk;
    logic       reset;
    logic       enable;
    logic [3:0] scoreOne, scoreTen, scoreHundred;
    logic [2:0] anodeN;
    logic [6:0] segN;
    logic       frameDone;

    int n_cmp = 0;
    int n_err = 0;

    score_display_scanner #(
        .SCAN_DIV     (SCAN_DIV)
`ifdef SCORE_BLINK_EN
        ,
        .BLINK_FRAMES (BLINK_FRAMES)
`endif
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .enable       (enable),
        .scoreOne     (scoreOne),
        .scoreTen     (scoreTen),
        .scoreHundred (scoreHundred),
        .anodeN       (anodeN),
        .segN         (segN),
        .frameDone    (frameDone)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", tag, obs, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------------
    // Reference model: position within the frame (-1 = idle, 0 = latch gap,
    // 1..3*SCAN_DIV = digit slots), the latched score and a blink counter.
    // ------------------------------------------------------------------------
    logic [6:0] seg_tbl [16];
    int         pos     = -1;
    logic [3:0] m_digit [3];
    int         m_blink = 0;
    logic       m_fd    = 1'b0;
    bit         started = 1'b0;

    initial begin
        seg_tbl = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                    7'b0000000, 7'b0010000, 7'b0000110, 7'b0000110,
                    7'b0000110, 7'b0000110, 7'b0000110, 7'b0000110};
        for (int i = 0; i < 3; i++) m_digit[i] = 4'd0;
    end

    always @(posedge clk) begin
        started = 1'b1;
        m_fd    = 1'b0;
        if (reset) begin
            pos     = -1;
            m_blink = 0;
            for (int i = 0; i < 3; i++) m_digit[i] = 4'd0;
        end else if (!enable) begin
            pos = -1;
        end else if (pos < 0) begin
            pos = 0;
        end else begin
            if (pos == 0) begin
`ifdef SCORE_BLINK_EN
                if (scoreOne != m_digit[0] || scoreTen != m_digit[1] || scoreHundred != m_digit[2])
                    m_blink = BLINK_FRAMES;
`endif
                m_digit[0] = scoreOne;
                m_digit[1] = scoreTen;
                m_digit[2] = scoreHundred;
            end
            pos = pos + 1;
            if (pos == FRAME) begin
                pos  = 0;
                m_fd = 1'b1;
                if (m_blink > 0) m_blink = m_blink - 1;
            end
        end
    end

    always @(negedge clk) begin
        if (started) begin
            logic [2:0] ea;
            logic [6:0] es;
            logic       blank;
            int         k;
            ea = 3'b111;
            es = 7'b1111111;
            if (pos > 0) begin
                k     = (pos - 1) / SCAN_DIV;
                ea[k] = 1'b0;
                blank = (k == 2 && m_digit[2] == 4'd0) ||
                        (k == 1 && m_digit[2] == 4'd0 && m_digit[1] == 4'd0) ||
                        ((m_blink % 2) == 1);
                if (!blank) es = seg_tbl[m_digit[k]];
            end
            check_eq("anodeN", 32'(anodeN), 32'(ea));
            check_eq("segN", 32'(segN), 32'(es));
            check_eq("frameDone", 32'(frameDone), 32'(m_fd));
        end
    end

    // ------------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------------
    task automatic run(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic set_score(input logic [3:0] h, input logic [3:0] t, input logic [3:0] o);
        scoreHundred = h;
        scoreTen     = t;
        scoreOne     = o;
    endtask

    task automatic wait_pos(input int target);
        int n;
        n = 0;
        while (pos != target && n < 3 * FRAME) begin
            @(negedge clk);
            n++;
        end
        check_eq("wait_pos_reached", 32'(pos == target), 32'd1);
    endtask

    task automatic wait_fd(output int cycles);
        cycles = 0;
        while (frameDone !== 1'b1 && cycles < 3 * FRAME) begin
            @(negedge clk);
            cycles++;
        end
        check_eq("frameDone_seen", 32'(cycles < 3 * FRAME), 32'd1);
    endtask

    function automatic logic [3:0] rand_digit();
        int r;
        r = int'($urandom_range(0, 9));
        if (r < 4)      return 4'd0;
        else if (r < 8) return 4'($urandom_range(1, 9));
        else            return 4'($urandom_range(10, 15));
    endfunction

    initial begin
        int c;
        reset  = 1'b1;
        enable = 1'b0;
        set_score(4'd0, 4'd0, 4'd0);
        run(3);
        check_eq("rst_anodeN", 32'(anodeN), 32'h7);
        check_eq("rst_segN", 32'(segN), 32'h7f);
        check_eq("rst_frameDone", 32'(frameDone), 32'd0);
        reset = 1'b0;

        // Hundreds 1, tens 3, ones 2; measure the frame period
        set_score(4'd1, 4'd3, 4'd2);
        enable = 1'b1;
        wait_fd(c);
        run(1);
        wait_fd(c);
        check_eq("frame_period", 32'(c + 1), 32'(FRAME));
        run(5);

        set_score(4'd0, 4'd0, 4'd0);
        run(2 * FRAME);
        set_score(4'd5, 4'd0, 4'd7);
        run(2 * FRAME);

        // Invalid ones digit, then an input change during DIG1
        set_score(4'd5, 4'd0, 4'hC);
        run(FRAME);
        wait_pos(1 + SCAN_DIV + 1);
        set_score(4'd8, 4'd8, 4'd8);
        run(2 * FRAME);

        // Enable dropped in the second cycle of DIG1
        wait_pos(1 + SCAN_DIV + 1);
        enable = 1'b0;
        run(1);
        check_eq("drop_anodeN", 32'(anodeN), 32'h7);
        check_eq("drop_segN", 32'(segN), 32'h7f);
        check_eq("drop_frameDone", 32'(frameDone), 32'd0);
        run(3);
        enable = 1'b1;
        run(1);
        check_eq("restart_latch_anodeN", 32'(anodeN), 32'h7);
        run(2 * FRAME);

        // Score 9 -> 10 and the blink sequence, then a reset mid-blink
        set_score(4'd0, 4'd0, 4'd9);
        run(6 * FRAME);
        wait_pos(1 + SCAN_DIV);
        set_score(4'd0, 4'd1, 4'd0);
        run(6 * FRAME);
        set_score(4'd0, 4'd2, 4'd0);
        run(FRAME + 5);
        reset = 1'b1;
        run(2);
        reset = 1'b0;
        run(3 * FRAME);

        // Randomized phase
        for (int i = 0; i < 700; i++) begin
            if ($urandom_range(0, 19) == 0)
                set_score(rand_digit(), rand_digit(), rand_digit());
            if ($urandom_range(0, 149) == 0) enable = ~enable;
            if (!enable && $urandom_range(0, 9) == 0) enable = 1'b1;
            reset = ($urandom_range(0, 399) == 0);
            run(1);
        end
        reset  = 1'b0;
        enable = 1'b1;
        run(2 * FRAME);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, compared %0d mismatched %0d", n_cmp, n_err);
        $fatal(1);
    end

endmodule : tb_score_display_scanner
`default_nettype wire

// File: doc/score_display_scanner.md
Name: score_display_scanner

Overview:
- Consumes the three BCD score digits (ones, tens, hundreds) produced by the game's score counter.
- Drives a 3-digit, common-anode, time-multiplexed 7-segment display.
- Snapshots all three digits once per scan frame so a digit rollover cannot tear the display mid-frame.
- Applies leading-zero blanking and flags invalid BCD codes by showing "E".

Parameters:
- SCAN_DIV, 50000: clk cycles each digit stays lit; legal range ≥ 2.
- BLINK_FRAMES, 8: number of frames in a score-change blink sequence; used only with SCORE_BLINK_EN.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- enable  in  1  1 = scan active; 0 = display blanked
- scoreOne  in  4  BCD ones digit
- scoreTen  in  4  BCD tens digit
- scoreHundred  in  4  BCD hundreds digit
- anodeN  out  3  active-low digit select; bit0 = ones, bit1 = tens, bit2 = hundreds
- segN  out  7  active-low segments {g,f,e,d,c,b,a}
- frameDone  out  1  one-cycle pulse when a frame completes

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on port reset.
- Reset values: state = IDLE, anodeN = 3'b111, segN = 7'b1111111, frameDone = 0, prescaler = 0, snapshot = 0.
- FSM states: IDLE, LATCH, DIG0, DIG1, DIG2.
- Outputs are registered and change on the same edge as the state register.
- IDLE: all outputs blank. Go to LATCH on the edge after enable = 1.
- LATCH: lasts exactly 1 cycle.
  - Copy the inputs into the snapshot registers.
  - anodeN = 3'b111 (anti-ghosting gap).
  - Go to DIG0 with the prescaler cleared.
- DIGk: lasts exactly SCAN_DIV cycles.
  - Only anode k is low; segN = decode(snapshot digit k).
  - The prescaler counts 0..SCAN_DIV-1. At terminal count, DIG0 → DIG1 → DIG2 → LATCH.
  - frameDone = 1 in the first cycle of LATCH entered from DIG2.
  - Frame length = 1 + 3*SCAN_DIV cycles.
- enable = 0 in any non-IDLE state: the next edge enters IDLE with outputs blanked, no frameDone, and the prescaler cleared.
- Input changes outside LATCH have no effect until the next LATCH.
- Decode table (active-low):
  - 0 = 1000000, 1 = 1111001, 2 = 0100100, 3 = 0110000, 4 = 0011001
  - 5 = 0010010, 6 = 0000010, 7 = 1111000, 8 = 0000000, 9 = 0010000
  - 10..15 = E = 0000110
- Leading-zero blanking:
  - Hundreds digit blanked (segN = 1111111) when its snapshot = 0.
  - Tens digit blanked when hundreds = 0 and tens = 0.
  - Ones digit is never blanked, so score 000 shows "0".
  - Anodes still scan when a digit is blanked.
  - An invalid digit (> 9) is never treated as zero for blanking.
- Reset asserted mid-frame: state and outputs take their reset values on that edge.

Optional Feature:
- Macro: SCORE_BLINK_EN.
- With the macro defined:
  - Keep the previous-frame snapshot. If a LATCH captures a value differing from it, load a blink counter with BLINK_FRAMES.
  - While the counter is nonzero, frames with odd counter values output segN = 1111111 on all digits; anode timing is unchanged.
  - The counter decrements at each frameDone.
  - A further change while blinking reloads the counter.
- Without the macro: no blink logic or registers; the display is always steady.

Decomposition:
- Package score_display_pkg holds:
  - the state enum typedef
  - SEG_BLANK, SEG_E and the digit pattern constants
  - ANODE_OFF
- Sub-module bcd_to_seg7: combinational 4-bit in, 7-bit active-low out, decodes 10..15 to E.
- The scanner instantiates one bcd_to_seg7, with its input muxed by the current digit.

Test Plan (SCAN_DIV = 4, BLINK_FRAMES = 4):
- Reset then enable = 1, score 1/2/3:
  - LATCH for 1 cycle with anodeN = 111.
  - Then anodeN = 110 / segN = 0100100 for 4 cycles, 101 / 0110000 for 4 cycles, 011 / 1111001 for 4 cycles.
  - frameDone pulses every 13 cycles.
- Score 0/0/0: ones shows 1000000; tens and hundreds show 1111111 with their anodes still low in turn.
- Score 0 tens, 5 hundreds, 7 ones: tens shows 1000000 (not blanked); hundreds shows 0010010.
- scoreOne = 4'hC: ones shows 0000110. A change of inputs during DIG1 does not alter the display until after the next LATCH.
- enable dropped in DIG1 cycle 2: next edge gives anodeN = 111, segN = 1111111, no frameDone. Re-enable restarts at LATCH.
- With SCORE_BLINK_EN, score 9 → 10 at a LATCH:
  - The next 4 frames alternate blank / visible, starting with the count-4 (visible) frame, then steady.
  - Reset mid-blink clears the counter.
